bitstream_unpacker: RTL and testbench

- Receiver for the entropy_encoder output interface (OUT_BIT_1..5, OUT_FLAG_BITSTREAM, OUT_FLAG_LAST).
- Captures each encoder output record into a descriptor FIFO, then expands it into a plain byte stream, one byte per cycle, under a valid/ready handshake.
- The encoder has no backpressure, so this block absorbs bursts and flags any loss.
- Sits between the encoder top and the system byte sink / frame buffer.

---
 rtl/bitstream_unpacker.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_bitstream_unpacker.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_unpacker.sv
// -----------------------------------------------------------------------------
// bitstream_unpacker
//
// Receives entropy_encoder output records and turns them into a plain byte
// stream with a valid/ready handshake. The encoder cannot be stalled, so each
// record goes into a descriptor FIFO first. An FSM pops one descriptor at a
// time and emits its bytes in order.
//
// Record formats (in_flag_bitstream):
//   0      : no bytes
//   1..3   : bit_1 .. bit_<flag>
//   5      : bit_1, then bit_2 repeated bit_3 times
//   6      : as 5, then bit_4
//   7      : as 6, then bit_5
//   4      : invalid; sets err_flag and the record is dropped
//
// Ports:
//   top_clk, top_reset    clock and asynchronous active-high reset
//   in_bit_1..in_bit_5    encoder byte lanes (bit_3 doubles as run count)
//   in_flag_bitstream     encoder record format
//   in_flag_last          encoder end-of-frame level; its rising edge marks
//                         the end of a frame
//   out_byte/out_valid    byte stream; a transfer happens on out_valid && out_ready
//   out_ready             sink ready
//   out_last              marks the final byte of a frame
//   out_frame_done        one-cycle pulse after a frame has fully drained
//   err_overflow          sticky; a record was lost because the FIFO was full
//   err_flag              sticky; a format-4 record was seen
//
// Optional build macro BITSTREAM_UNPACKER_BYTE_COUNT_EN adds the
// out_frame_bytes [31:0] output. It holds the byte count of the most recently
// completed frame.
// -----------------------------------------------------------------------------
module bitstream_unpacker #(
    parameter int BITSTREAM_WIDTH = 8,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                       top_clk,
    input  logic                       top_reset,
    input  logic [BITSTREAM_WIDTH-1:0] in_bit_1,
    input  logic [BITSTREAM_WIDTH-1:0] in_bit_2,
    input  logic [BITSTREAM_WIDTH-1:0] in_bit_3,
    input  logic [BITSTREAM_WIDTH-1:0] in_bit_4,
    input  logic [BITSTREAM_WIDTH-1:0] in_bit_5,
    input  logic [2:0]                 in_flag_bitstream,
    input  logic                       in_flag_last,
    output logic [BITSTREAM_WIDTH-1:0] out_byte,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       out_frame_done,
    output logic                       err_overflow,
    output logic                       err_flag
`ifdef BITSTREAM_UNPACKER_BYTE_COUNT_EN
    ,
    output logic [31:0]                out_frame_bytes
`endif
);

    localparam int W  = BITSTREAM_WIDTH;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef struct packed {
        logic [W-1:0] b1;
        logic [W-1:0] b2;
        logic [W-1:0] b3;
        logic [W-1:0] b4;
        logic [W-1:0] b5;
        logic [2:0]   flag;
        logic         last;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_B1   = 3'd1,
        S_B2   = 3'd2,
        S_B3   = 3'd3,
        S_RUN  = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_DONE = 3'd7
    } state_t;

    // ---------------------------------------------------------------------
    // Capture side
    // ---------------------------------------------------------------------
    logic          last_q, last_d;
    logic          last_evt;
    logic          flag_is_data;
    logic          flag_is_bad;
    logic          wr_req;
    entry_t        wr_entry;

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    entry_t        mem_q [FIFO_DEPTH];
    entry_t        rd_entry;

    logic          err_overflow_q, err_overflow_d;
    logic          err_flag_q, err_flag_d;

    assign last_d       = in_flag_last;
    assign last_evt     = in_flag_last & ~last_q;
    assign flag_is_bad  = (in_flag_bitstream == 3'd4);
    assign flag_is_data = (in_flag_bitstream != 3'd0) && !flag_is_bad;
    assign wr_req       = flag_is_data | last_evt;

    always_comb begin
        wr_entry.b1   = in_bit_1;
        wr_entry.b2   = in_bit_2;
        wr_entry.b3   = in_bit_3;
        wr_entry.b4   = in_bit_4;
        wr_entry.b5   = in_bit_5;
        // An invalid record that coincides with an end-of-frame edge still
        // has to close the frame, so it becomes an empty record.
        wr_entry.flag = flag_is_bad ? 3'd0 : in_flag_bitstream;
        wr_entry.last = last_evt;
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_entry   = mem_q[rd_ptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot that the write lands in. The
    // popped entry is read combinationally before the edge, so it is safe.
    assign push = wr_req && (!fifo_full || pop);

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        err_overflow_d = err_overflow_q;
        err_flag_d     = err_flag_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        if (wr_req && fifo_full && !pop) begin
            err_overflow_d = 1'b1;
        end
        if (flag_is_bad) begin
            err_flag_d = 1'b1;
        end
    end

    always_ff @(posedge top_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

    // ---------------------------------------------------------------------
    // Expansion FSM
    // ---------------------------------------------------------------------
    state_t        state_q, state_d;
    entry_t        wk_q, wk_d;
    logic [W-1:0]  run_cnt_q, run_cnt_d;
    logic          final_byte;
    state_t        end_state;

    assign end_state = wk_q.last ? S_DONE : S_IDLE;

    always_comb begin
        state_d        = state_q;
        wk_d           = wk_q;
        run_cnt_d      = run_cnt_q;
        pop            = 1'b0;
        out_valid      = 1'b0;
        out_byte       = '0;
        final_byte     = 1'b0;
        out_frame_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    wk_d      = rd_entry;
                    run_cnt_d = rd_entry.b3;
                    state_d   = (rd_entry.flag != 3'd0) ? S_B1 : S_DONE;
                end
            end

            S_B1: begin
                out_valid  = 1'b1;
                out_byte   = wk_q.b1;
                final_byte = (wk_q.flag == 3'd1) ||
                             ((wk_q.flag == 3'd5) && (run_cnt_q == '0));
                if (out_ready) begin
                    if ((wk_q.flag == 3'd2) || (wk_q.flag == 3'd3)) begin
                        state_d = S_B2;
                    end else if (wk_q.flag >= 3'd5) begin
                        // A zero run count skips RUN entirely.
                        if (run_cnt_q != '0) begin
                            state_d = S_RUN;
                        end else if (wk_q.flag >= 3'd6) begin
                            state_d = S_T4;
                        end else begin
                            state_d = end_state;
                        end
                    end else begin
                        state_d = end_state;
                    end
                end
            end

            S_B2: begin
                out_valid  = 1'b1;
                out_byte   = wk_q.b2;
                final_byte = (wk_q.flag == 3'd2);
                if (out_ready) begin
                    state_d = (wk_q.flag == 3'd3) ? S_B3 : end_state;
                end
            end

            S_B3: begin
                out_valid  = 1'b1;
                out_byte   = wk_q.b3;
                final_byte = 1'b1;
                if (out_ready) begin
                    state_d = end_state;
                end
            end

            S_RUN: begin
                out_valid  = 1'b1;
                out_byte   = wk_q.b2;
                final_byte = (wk_q.flag == 3'd5) && (run_cnt_q == W'(1));
                if (out_ready) begin
                    run_cnt_d = run_cnt_q - W'(1);
                    if (run_cnt_q == W'(1)) begin
                        state_d = (wk_q.flag >= 3'd6) ? S_T4 : end_state;
                    end
                end
            end

            S_T4: begin
                out_valid  = 1'b1;
                out_byte   = wk_q.b4;
                final_byte = (wk_q.flag == 3'd6);
                if (out_ready) begin
                    state_d = (wk_q.flag == 3'd7) ? S_T5 : end_state;
                end
            end

            S_T5: begin
                out_valid  = 1'b1;
                out_byte   = wk_q.b5;
                final_byte = 1'b1;
                if (out_ready) begin
                    state_d = end_state;
                end
            end

            S_DONE: begin
                out_frame_done = 1'b1;
                state_d        = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_last     = final_byte & wk_q.last;
    assign err_overflow = err_overflow_q;
    assign err_flag     = err_flag_q;

    // Working record is pure data; it is only observed in emit states, which
    // are always entered through a pop that loads it.
    always_ff @(posedge top_clk) begin
        wk_q <= wk_d;
    end

    always_ff @(posedge top_clk or posedge top_reset) begin
        if (top_reset) begin
            state_q        <= S_IDLE;
            run_cnt_q      <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            last_q         <= 1'b0;
            err_overflow_q <= 1'b0;
            err_flag_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            run_cnt_q      <= run_cnt_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            last_q         <= last_d;
            err_overflow_q <= err_overflow_d;
            err_flag_q     <= err_flag_d;
        end
    end

`ifdef BITSTREAM_UNPACKER_BYTE_COUNT_EN
    // ---------------------------------------------------------------------
    // Per-frame byte counter
    // ---------------------------------------------------------------------
    logic [31:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] frame_bytes_q, frame_bytes_d;

    // No transfer can occur in DONE, so the running count already includes
    // the frame's final byte when it is latched.
    always_comb begin
        byte_cnt_d    = byte_cnt_q;
        frame_bytes_d = frame_bytes_q;
        if (state_q == S_DONE) begin
            frame_bytes_d = byte_cnt_q;
            byte_cnt_d    = '0;
        end else if (out_valid && out_ready) begin
            byte_cnt_d = byte_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge top_clk or posedge top_reset) begin
        if (top_reset) begin
            byte_cnt_q    <= '0;
            frame_bytes_q <= '0;
        end else begin
            byte_cnt_q    <= byte_cnt_d;
            frame_bytes_q <= frame_bytes_d;
        end
    end

    assign out_frame_bytes = frame_bytes_q;
`endif

endmodule

// File: tb/tb_bitstream_unpacker.sv
// -----------------------------------------------------------------------------
// tb_bitstream_unpacker
//
// Directed bench for bitstream_unpacker. A table of single records with
// hand-computed byte sequences is applied first. Hand-written sequences then
// cover overflow under backpressure, invalid records and reset mid-run.
// -----------------------------------------------------------------------------
module tb_bitstream_unpacker;

    localparam int W     = 8;
    localparam int DEPTH = 8;

    logic          top_clk;
    logic          top_reset;
    logic [W-1:0]  in_bit_1, in_bit_2, in_bit_3, in_bit_4, in_bit_5;
    logic [2:0]    in_flag_bitstream;
    logic          in_flag_last;
    logic [W-1:0]  out_byte;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          out_frame_done;
    logic          err_overflow;
    logic          err_flag;
`ifdef BITSTREAM_UNPACKER_BYTE_COUNT_EN
    logic [31:0]   out_frame_bytes;
`endif

    bitstream_unpacker #(
        .BITSTREAM_WIDTH (W),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .top_clk           (top_clk),
        .top_reset         (top_reset),
        .in_bit_1          (in_bit_1),
        .in_bit_2          (in_bit_2),
        .in_bit_3          (in_bit_3),
        .in_bit_4          (in_bit_4),
        .in_bit_5          (in_bit_5),
        .in_flag_bitstream (in_flag_bitstream),
        .in_flag_last      (in_flag_last),
        .out_byte          (out_byte),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_last          (out_last),
        .out_frame_done    (out_frame_done),
        .err_overflow      (err_overflow),
        .err_flag          (err_flag)
`ifdef BITSTREAM_UNPACKER_BYTE_COUNT_EN
        ,
        .out_frame_bytes   (out_frame_bytes)
`endif
    );

    initial top_clk = 1'b0;
    always #5 top_clk = ~top_clk;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic [7:0]  b4;
        logic [7:0]  b5;
        logic [2:0]  flag;
        logic        last;
        logic [3:0]  n;     // number of expected bytes
        logic [63:0] exp;   // expected bytes, first byte in [7:0]
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge top_clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                         input logic [7:0] b4, input logic [7:0] b5,
                         input logic [2:0] flag, input logic last);
        in_bit_1          = b1;
        in_bit_2          = b2;
        in_bit_3          = b3;
        in_bit_4          = b4;
        in_bit_5          = b5;
        in_flag_bitstream = flag;
        in_flag_last      = last;
    endtask

    task automatic idle_in();
        drive(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
    endtask

    initial begin
        logic [63:0] e;
        int          frame_cnt;
        int          got;

        frame_cnt = 0;
        got       = 0;

        vecs[0] = '{b1:8'h11, b2:8'h22, b3:8'h33, b4:8'h00, b5:8'h00, flag:3'd3, last:1'b0,
                    n:4'd3, exp:64'h0000_0000_0033_2211};
        vecs[1] = '{b1:8'hA0, b2:8'hFF, b3:8'h03, b4:8'h01, b5:8'h02, flag:3'd7, last:1'b0,
                    n:4'd6, exp:64'h0000_0201_FFFF_FFA0};
        vecs[2] = '{b1:8'h5A, b2:8'h66, b3:8'h00, b4:8'h77, b5:8'h88, flag:3'd5, last:1'b0,
                    n:4'd1, exp:64'h0000_0000_0000_005A};
        vecs[3] = '{b1:8'h7E, b2:8'h00, b3:8'h00, b4:8'h00, b5:8'h00, flag:3'd1, last:1'b1,
                    n:4'd1, exp:64'h0000_0000_0000_007E};
        vecs[4] = '{b1:8'hC3, b2:8'h3C, b3:8'h99, b4:8'h00, b5:8'h00, flag:3'd2, last:1'b0,
                    n:4'd2, exp:64'h0000_0000_0000_3CC3};
        vecs[5] = '{b1:8'h10, b2:8'h20, b3:8'h02, b4:8'h40, b5:8'h50, flag:3'd6, last:1'b0,
                    n:4'd4, exp:64'h0000_0000_4020_2010};
        vecs[6] = '{b1:8'h01, b2:8'h02, b3:8'h01, b4:8'h00, b5:8'h00, flag:3'd5, last:1'b1,
                    n:4'd2, exp:64'h0000_0000_0000_0201};

        // ---------------- reset state ----------------
        top_reset = 1'b1;
        out_ready = 1'b1;
        idle_in();
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_byte", out_byte, 0);
        chk("rst_last", out_last, 0);
        chk("rst_done", out_frame_done, 0);
        chk("rst_ovf", err_overflow, 0);
        chk("rst_errflag", err_flag, 0);
`ifdef BITSTREAM_UNPACKER_BYTE_COUNT_EN
        chk("rst_frame_bytes", out_frame_bytes, 0);
`endif
        top_reset = 1'b0;
        tick();

        // ---------------- table of single records ----------------
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].b1, vecs[i].b2, vecs[i].b3, vecs[i].b4, vecs[i].b5,
                  vecs[i].flag, vecs[i].last);
            tick();
            idle_in();
            // capture edge done, pop not yet: nothing visible
            chk("lat_early", out_valid, 0);
            tick();
            e = vecs[i].exp;
            for (int k = 0; k < int'(vecs[i].n); k++) begin
                chk("vec_valid", out_valid, 1);
                chk("vec_byte", out_byte, e[8*k +: 8]);
                chk("vec_last", out_last, (vecs[i].last && (k == int'(vecs[i].n) - 1)) ? 1 : 0);
                tick();
            end
            frame_cnt += int'(vecs[i].n);
            if (vecs[i].last) begin
                chk("vec_done_pulse", out_frame_done, 1);
                chk("vec_done_novalid", out_valid, 0);
                tick();
                chk("vec_done_clear", out_frame_done, 0);
`ifdef BITSTREAM_UNPACKER_BYTE_COUNT_EN
                chk("vec_frame_bytes", out_frame_bytes, frame_cnt);
`endif
                frame_cnt = 0;
            end
            chk("vec_idle_after", out_valid, 0);
        end

        // ---------------- overflow under backpressure ----------------
        // The FSM pops the first record into its working register even while
        // stalled, so DEPTH+1 records still fit and the next one overflows.
        out_ready = 1'b0;
        for (int j = 0; j < DEPTH + 1; j++) begin
            drive(8'h80 + 8'(j), 8'h00, 8'h00, 8'h00, 8'h00, 3'd1, 1'b0);
            tick();
        end
        idle_in();
        chk("ovf_not_yet", err_overflow, 0);
        chk("stall_valid", out_valid, 1);
        chk("stall_byte0", out_byte, 8'h80);
        drive(8'hEE, 8'h00, 8'h00, 8'h00, 8'h00, 3'd1, 1'b0);
        tick();
        idle_in();
        chk("ovf_set", err_overflow, 1);
        tick();
        tick();
        chk("stall_byte1", out_byte, 8'h80);
        chk("stall_last", out_last, 0);
        chk("stall_valid1", out_valid, 1);

        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) begin
                chk("drain_byte", out_byte, 8'h80 + 8'(got));
                got++;
            end
            tick();
        end
        chk("drain_count", got, DEPTH + 1);
        chk("ovf_sticky", err_overflow, 1);
        frame_cnt += got;

        // ---------------- invalid record ----------------
        drive(8'h99, 8'h98, 8'h97, 8'h96, 8'h95, 3'd4, 1'b0);
        tick();
        idle_in();
        chk("errflag_set", err_flag, 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bad_no_bytes", out_valid, 0);
        end

        // invalid record with an end-of-frame edge becomes an empty record
        drive(8'h99, 8'h98, 8'h97, 8'h96, 8'h95, 3'd4, 1'b1);
        tick();
        idle_in();
        chk("badlast_no_valid", out_valid, 0);
        tick();
        chk("badlast_done", out_frame_done, 1);
        chk("badlast_no_valid2", out_valid, 0);
        tick();
        chk("badlast_done_clear", out_frame_done, 0);
`ifdef BITSTREAM_UNPACKER_BYTE_COUNT_EN
        chk("badlast_frame_bytes", out_frame_bytes, frame_cnt);
`endif
        frame_cnt = 0;

        // ---------------- reset in the middle of a run ----------------
        drive(8'h01, 8'h02, 8'h05, 8'h04, 8'h05, 3'd7, 1'b0);
        tick();
        drive(8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 3'd1, 1'b0);  // left queued in FIFO
        tick();
        idle_in();
        chk("mid_b1", out_byte, 8'h01);
        tick();
        chk("mid_run_valid", out_valid, 1);
        chk("mid_run_byte", out_byte, 8'h02);
        top_reset = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_byte", out_byte, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_done", out_frame_done, 0);
        chk("mid_rst_ovf", err_overflow, 0);
        chk("mid_rst_errflag", err_flag, 0);
`ifdef BITSTREAM_UNPACKER_BYTE_COUNT_EN
        chk("mid_rst_frame_bytes", out_frame_bytes, 0);
`endif
        tick();
        top_reset = 1'b0;
        tick();
        tick();
        chk("post_rst_empty", out_valid, 0);

        drive(8'h5C, 8'h00, 8'h00, 8'h00, 8'h00, 3'd1, 1'b0);
        tick();
        idle_in();
        tick();
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_byte", out_byte, 8'h5C);
        tick();
        chk("post_rst_idle", out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
